// File: rtl/game_state_controller.sv
// rtl/game_state_controller.sv - frame-sampled game sequencer: lives, score, respawn and game-over control
module game_state_controller #(
  parameter int         START_LIVES    = 3,
  parameter int         RESPAWN_FRAMES = 60,
  parameter logic [7:0] SPAWN_POS      = 8'h15,
  parameter int         SCORE_W        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_end,
  input  logic [9:0]         input_data,
  input  logic [7:0]         player_pos,
  input  logic [7:0]         sword_position,
  input  logic [3:0]         sword_visible,
  input  logic [7:0]         enemy_pos,
  output logic [9:0]         gated_input,
  output logic [1:0]         game_state,
  output logic [1:0]         player_lives,
  output logic [SCORE_W-1:0] score,
  output logic               player_respawn,
  output logic [7:0]         respawn_pos,
  output logic               enemy_hit
);

  typedef enum logic [1:0] {
    S_START     = 2'b00,
    S_PLAY      = 2'b01,
    S_RESPAWN   = 2'b10,
    S_GAME_OVER = 2'b11
  } state_t;

  localparam logic [1:0] LP_START_LIVES = 2'(START_LIVES);
  localparam logic [7:0] LP_RESP_FRAMES = 8'(RESPAWN_FRAMES);

  state_t             r_state;
  state_t             w_next_state;
  logic [1:0]         r_lives, w_lives_nxt;
  logic [SCORE_W-1:0] r_score, w_score_nxt, w_score_inc;
  logic [7:0]         r_cnt, w_cnt_nxt;
  logic               r_respawn, w_respawn_nxt;
  logic               r_hit, w_hit_nxt;
  logic               r_bit9_prev;
  logic               r_armed;
  logic               w_start_press;
  logic               w_sword_hit;
  logic               w_collide;

  // r_armed blocks a button held through reset from counting as a press
  assign w_start_press = frame_end & input_data[9] & ~r_bit9_prev & r_armed;
  assign w_sword_hit   = (sword_visible == 4'b0001) && (sword_position == enemy_pos);
  assign w_collide     = (player_pos == enemy_pos);
  assign w_score_inc   = (&r_score) ? r_score : r_score + SCORE_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_START;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (frame_end) begin
      case (r_state)
        S_START:     if (w_start_press) w_next_state = S_PLAY;
        S_PLAY:      if (!w_sword_hit && w_collide)
                       w_next_state = (r_lives > 2'd1) ? S_RESPAWN : S_GAME_OVER;
        S_RESPAWN:   if (r_cnt <= 8'd1) w_next_state = S_PLAY;
        S_GAME_OVER: if (w_start_press) w_next_state = S_START;
        default:     w_next_state = S_START;
      endcase
    end
  end

  always_comb begin
    w_lives_nxt   = r_lives;
    w_score_nxt   = r_score;
    w_cnt_nxt     = r_cnt;
    w_respawn_nxt = 1'b0;
    w_hit_nxt     = 1'b0;
    if (frame_end) begin
      case (r_state)
        S_START: if (w_start_press) begin
          w_lives_nxt   = LP_START_LIVES;
          w_score_nxt   = '0;
          w_respawn_nxt = 1'b1;
        end
        S_PLAY: begin
          if (w_sword_hit) begin
            w_hit_nxt   = 1'b1;
            w_score_nxt = w_score_inc;
          end else if (w_collide) begin
            if (r_lives > 2'd1) begin
              w_lives_nxt   = r_lives - 2'd1;
              w_cnt_nxt     = LP_RESP_FRAMES;
              w_respawn_nxt = 1'b1;
            end else begin
              w_lives_nxt = 2'd0;
            end
          end
        end
        S_RESPAWN: begin
          if (w_sword_hit) begin
            w_hit_nxt   = 1'b1;
            w_score_nxt = w_score_inc;
          end
          w_cnt_nxt = (r_cnt != 8'd0) ? r_cnt - 8'd1 : 8'd0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lives     <= 2'd0;
      r_score     <= '0;
      r_cnt       <= 8'd0;
      r_respawn   <= 1'b0;
      r_hit       <= 1'b0;
      r_bit9_prev <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_lives   <= w_lives_nxt;
      r_score   <= w_score_nxt;
      r_cnt     <= w_cnt_nxt;
      r_respawn <= w_respawn_nxt;
      r_hit     <= w_hit_nxt;
      if (frame_end) begin
        r_bit9_prev <= input_data[9];
        if (!input_data[9]) r_armed <= 1'b1;
      end
    end
  end

  assign gated_input    = (r_state == S_PLAY || r_state == S_RESPAWN) ? input_data : 10'd0;
  assign game_state     = r_state;
  assign player_lives   = r_lives;
  assign score          = r_score;
  assign player_respawn = r_respawn;
  assign respawn_pos    = SPAWN_POS;
  assign enemy_hit      = r_hit;

endmodule
